// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between a CPU load/store port and a word-write loader onto one data RAM.
// Latency: ack two cycles after the request is sampled in IDLE; one access per three cycles.
// Backpressure: requesters hold req until their ack; requests are only sampled while IDLE.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic                     cpu_ww,
    input  logic                     cpu_rb,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_ack,
    input  logic                     ldr_req,
    input  logic [ADDRESS_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0]    ldr_wdata,
    output logic                     ldr_ack,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     err,
    output logic                     ram_we,
    output logic                     ram_ww,
    output logic                     ram_rb,
    output logic [ADDRESS_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0]    ram_wd,
    input  logic [DATA_WIDTH-1:0]    ram_rd,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state;
    logic                     last_grant;   // 1: loader was granted last
    logic                     cmd_we;
    logic                     cmd_ww;
    logic                     cmd_rb;
    logic                     cmd_owner;    // 1: loader owns the access
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;

    logic grant_ldr;
    logic misaligned;
    logic in_access;

    // Loader wins when alone, or on a tie when the CPU had the previous grant.
    assign grant_ldr  = ldr_req && (!cpu_req || !last_grant);
    // Word writes and word reads must be 4-byte aligned; byte accesses may sit anywhere.
    assign misaligned = (cmd_addr[1:0] != 2'b00) && (cmd_we ? cmd_ww : !cmd_rb);
    assign in_access  = (state == ACCESS);

    assign busy   = (state != IDLE);
    assign ram_we = in_access && cmd_we && !misaligned && !rst;
    assign ram_ww = in_access ? cmd_ww : 1'b0;
    assign ram_rb = in_access ? cmd_rb : 1'b0;
    assign ram_a  = in_access ? cmd_addr : '0;
    assign ram_wd = in_access ? cmd_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cmd_we     <= 1'b0;
            cmd_ww     <= 1'b0;
            cmd_rb     <= 1'b0;
            cmd_owner  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || ldr_req) begin
                        state      <= ACCESS;
                        last_grant <= grant_ldr;
                        cmd_owner  <= grant_ldr;
                        if (grant_ldr) begin
                            cmd_we    <= 1'b1;
                            cmd_ww    <= 1'b1;
                            cmd_rb    <= 1'b0;
                            cmd_addr  <= ldr_addr;
                            cmd_wdata <= ldr_wdata;
                        end else begin
                            cmd_we    <= cpu_we;
                            cmd_ww    <= cpu_ww;
                            cmd_rb    <= cpu_rb;
                            cmd_addr  <= cpu_addr;
                            cmd_wdata <= cpu_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state   <= DONE;
                    cpu_ack <= !cmd_owner;
                    ldr_ack <= cmd_owner;
                    err     <= misaligned;
                    if (!cmd_we) begin
                        if (misaligned)
                            rdata <= '0;
                        else if (cmd_rb)
                            rdata <= {{(DATA_WIDTH-8){1'b0}}, ram_rd[7:0]};
                        else
                            rdata <= ram_rd;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a transaction-level memory model and directed corner cases.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_ww = 1'b0, cpu_rb = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic        ldr_req = 1'b0;
    logic [11:0] ldr_addr = '0;
    logic [31:0] ldr_wdata = '0;
    logic        ldr_ack;
    logic [31:0] rdata;
    logic        err;
    logic        ram_we, ram_ww, ram_rb;
    logic [11:0] ram_a;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem       [0:1023];
    logic [31:0] model_mem [0:1023];
    logic [31:0] model_rdata;
    logic        poke_en = 1'b0;
    logic [9:0]  poke_idx = '0;
    logic [31:0] poke_dat = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ww(cpu_ww), .cpu_rb(cpu_rb),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .rdata(rdata), .err(err),
        .ram_we(ram_we), .ram_ww(ram_ww), .ram_rb(ram_rb),
        .ram_a(ram_a), .ram_wd(ram_wd), .ram_rd(ram_rd), .busy(busy)
    );

    // Data RAM: byte reads return the addressed byte in the low lane; byte writes touch one lane.
    always_comb begin
        logic [31:0] w;
        w = mem[ram_a[11:2]];
        ram_rd = ram_rb ? (w >> {ram_a[1:0], 3'b000}) : w;
    end

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_idx] <= poke_dat;
        else if (ram_we) begin
            if (ram_ww)
                mem[ram_a[11:2]] <= ram_wd;
            else
                mem[ram_a[11:2]][{ram_a[1:0], 3'b000} +: 8] <= ram_wd[7:0];
        end
    end

    task automatic poke(input int idx, input logic [31:0] v);
        poke_en  = 1'b1;
        poke_idx = idx[9:0];
        poke_dat = v;
        model_mem[idx] = v;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_rdata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 ||
            busy !== 1'b0 || ram_we !== 1'b0 || ram_a !== 12'h0)
            begin
                errors++;
                $display("FAIL reset: cpu_ack=%b ldr_ack=%b err=%b rdata=%h busy=%b ram_we=%b ram_a=%h, required all zero",
                         cpu_ack, ldr_ack, err, rdata, busy, ram_we, ram_a);
            end
        rst = 1'b0;
    endtask

    // One complete transaction from a single requester, checked against the model.
    task automatic do_op(input bit ldr, input bit we, input bit ww, input bit rb,
                         input logic [11:0] a, input logic [31:0] wd, input string tag);
        bit          ew, eww, erb, mis, dn;
        int          lat;
        logic [31:0] word, sh, exp_rd;
        ew  = ldr ? 1'b1 : we;
        eww = ldr ? 1'b1 : ww;
        erb = ldr ? 1'b0 : rb;
        mis = (a[1:0] != 2'b00) && (ew ? eww : !erb);
        word = model_mem[a[11:2]];
        sh   = word >> (8 * a[1:0]);
        if (ew)       exp_rd = model_rdata;
        else if (mis) exp_rd = 32'h0;
        else if (erb) exp_rd = {24'h0, sh[7:0]};
        else          exp_rd = word;

        @(posedge clk);
        #1;
        checks++;
        if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: cpu_ack=%b ldr_ack=%b busy=%b, required 0 0 0", tag, cpu_ack, ldr_ack, busy);
        end
        if (ldr) begin
            ldr_req = 1'b1; ldr_addr = a; ldr_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_ww = ww; cpu_rb = rb; cpu_addr = a; cpu_wdata = wd;
        end
        lat = 0;
        dn  = 1'b0;
        while (!dn && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                checks++;
                if (ram_we !== (ew && !mis) || ram_a !== a || ram_ww !== eww || ram_rb !== erb || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s access: we=%b a=%h ww=%b rb=%b busy=%b, required we=%b a=%h ww=%b rb=%b busy=1",
                             tag, ram_we, ram_a, ram_ww, ram_rb, busy, ew && !mis, a, eww, erb);
                end
            end
            if (cpu_ack || ldr_ack) dn = 1'b1;
        end
        checks++;
        if (!dn || lat != 2 || cpu_ack !== !ldr || ldr_ack !== ldr) begin
            errors++;
            $display("FAIL %s ack: seen=%b after %0d cycles cpu_ack=%b ldr_ack=%b, required 2 cycles owner ldr=%b",
                     tag, dn, lat, cpu_ack, ldr_ack, ldr);
        end
        checks++;
        if (err !== mis) begin
            errors++;
            $display("FAIL %s err: got %b, required %b", tag, err, mis);
        end
        if (!ldr) begin
            checks++;
            if (rdata !== exp_rd) begin
                errors++;
                $display("FAIL %s rdata: got %h, required %h", tag, rdata, exp_rd);
            end
        end
        checks++;
        if (ram_we !== 1'b0 || ram_a !== 12'h0 || ram_wd !== 32'h0) begin
            errors++;
            $display("FAIL %s done_ram_idle: we=%b a=%h wd=%h, required zero", tag, ram_we, ram_a, ram_wd);
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        if (ew && !mis) begin
            if (eww) model_mem[a[11:2]] = wd;
            else     model_mem[a[11:2]][8 * a[1:0] +: 8] = wd[7:0];
        end
        model_rdata = exp_rd;
    endtask

    task automatic test_store_load();
        do_op(1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF, "store_word");
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_mem: got %h, required deadbeef", mem[4]);
        end
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0, "load_word");
    endtask

    task automatic test_misaligned();
        do_op(1'b0, 1'b1, 1'b1, 1'b0, 12'h012, 32'h11223344, "misaligned_write");
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misaligned_mem: got %h, required deadbeef", mem[4]);
        end
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 12'h011, 32'h0, "misaligned_read");
        do_op(1'b1, 1'b1, 1'b1, 1'b0, 12'h023, 32'h55667788, "misaligned_loader");
    endtask

    task automatic test_byte_read();
        poke(4, 32'hA5000000);
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 12'h013, 32'h0, "byte_read");
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, 32'h0, "byte_read_top");
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, 32'h0000005A, "byte_write_top");
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, 32'h0, "byte_readback_top");
    endtask

    task automatic test_reset_abort();
        do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        ldr_req = 1'b1; ldr_addr = 12'h020; ldr_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_we: ram_we=%b busy=%b, required 0 1", ram_we, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ldr_req = 1'b0;
        checks++;
        if (busy !== 1'b0 || ldr_ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b ldr_ack=%b, required 0 0", busy, ldr_ack);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ldr_ack !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_noack: cycle %0d ldr_ack=%b busy=%b, required 0 0", i, ldr_ack, busy);
            end
        end
        checks++;
        if (mem[8] !== model_mem[8]) begin
            errors++;
            $display("FAIL abort_mem: got %h, required %h", mem[8], model_mem[8]);
        end
    endtask

    task automatic test_arbitration();
        int          own [$];
        int          cyc [$];
        logic [31:0] sh;
        do_reset();
        rst = 1'b0;
        sh = model_mem[4] >> 24;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_ww = 1'b0; cpu_rb = 1'b1; cpu_addr = 12'h013;
        ldr_req = 1'b1; ldr_addr = 12'h100; ldr_wdata = 32'h0BADF00D;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (cpu_ack && ldr_ack) begin
                errors++;
                $display("FAIL arb_overlap: both acks high at cycle %0d", c);
            end
            if (cpu_ack) begin
                own.push_back(0); cyc.push_back(c);
                checks++;
                if (rdata !== {24'h0, sh[7:0]}) begin
                    errors++;
                    $display("FAIL arb_rdata: got %h, required %h", rdata, {24'h0, sh[7:0]});
                end
            end
            if (ldr_ack) begin
                own.push_back(1); cyc.push_back(c);
            end
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        model_mem[12'h100 >> 2] = 32'h0BADF00D;
        model_rdata = {24'h0, sh[7:0]};
        checks++;
        if (own.size() != 7) begin
            errors++;
            $display("FAIL arb_count: got %0d acks, required 7", own.size());
        end
        for (int k = 0; k < 6 && k < own.size(); k++) begin
            checks++;
            if (own[k] != (k % 2) || cyc[k] != 2 + 3 * k) begin
                errors++;
                $display("FAIL arb_order: ack %0d owner=%0d cycle=%0d, required owner=%0d cycle=%0d",
                         k, own[k], cyc[k], k % 2, 2 + 3 * k);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 60; n++) begin
            bit          ldr, we, ww, rb;
            logic [11:0] a;
            ldr = ($urandom_range(0, 3) == 0);
            we  = $urandom_range(0, 1);
            ww  = $urandom_range(0, 1);
            rb  = we ? 1'b0 : 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(12'hFF0, 12'hFFF))
                                                : 12'($urandom_range(0, 63));
            do_op(ldr, we, ww, rb, a, $urandom, "random");
        end
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== model_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_mem: %0d words differ, required 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) poke(i, $urandom);
        test_reset();
        test_store_load();
        test_misaligned();
        test_byte_read();
        test_arbitration();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 12, data-memory byte address width.
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_req  input  1  CPU load/store request; held high until cpu_ack.
REQ-006 cpu_we / cpu_ww / cpu_rb  input  1 each  write enable / word-write / byte-read qualifiers.
REQ-007 cpu_addr  input  ADDRESS_WIDTH  CPU byte address.
REQ-008 cpu_wdata  input  DATA_WIDTH  CPU store data.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-010 ldr_req  input  1  loader (word-write-only) request; held high until ldr_ack.
REQ-011 ldr_addr / ldr_wdata  input  ADDRESS_WIDTH / DATA_WIDTH  loader address and word.
REQ-012 ldr_ack  output  1  one-cycle completion pulse to loader.
REQ-013 rdata  output  DATA_WIDTH  registered read data, valid while cpu_ack high.
REQ-014 err  output  1  misaligned-word flag, valid with either ack.
REQ-015 ram_we / ram_ww / ram_rb  output  1 each  data-RAM WE, WW, RB controls.
REQ-016 ram_a / ram_wd  output  ADDRESS_WIDTH / DATA_WIDTH  data-RAM address and write data.
REQ-017 ram_rd  input  DATA_WIDTH  data-RAM asynchronous read data.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS on any granted request; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-020 Requests SHALL be sampled only in IDLE; requests arriving in ACCESS/DONE wait.
REQ-021 Arbitration SHALL be round-robin: sole requester wins; if both request, the one not granted last wins; last_grant updates on each grant.
REQ-022 On grant, command (we, ww, rb, addr, wdata, owner) SHALL be latched; loader commands latch as we=1, ww=1, rb=0.
REQ-023 In ACCESS, ram_a/ram_wd/ram_ww/ram_rb SHALL be driven from the latched command; outside ACCESS they SHALL be 0.
REQ-024 ram_we SHALL be high only in ACCESS, only when latched we=1, err condition false and rst low (gated combinationally).
REQ-025 Misaligned word: latched ww=1 (write) or rb=0 (read) with addr[1:0]!=0 SHALL set err in DONE and suppress ram_we; read then returns rdata=0.
REQ-026 In ACCESS, rdata SHALL capture ram_rd on the clock edge: {zeros, ram_rd[7:0]} when rb=1, full ram_rd otherwise; writes leave rdata unchanged.
REQ-027 In DONE, exactly one of cpu_ack/ldr_ack (the owner's) SHALL be high for exactly one cycle; err valid same cycle.
REQ-028 Latency SHALL be exactly 2 cycles from request sampled in IDLE (cycle N) to ack (cycle N+2); max throughput one access per 3 cycles.
REQ-029 A requester holding req high in the DONE cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-030 Addresses SHALL not wrap: aligned words never cross the top of memory; byte accesses to 2**ADDRESS_WIDTH-1 are legal.

Reset
REQ-031 While rst is high on a clock edge: state=IDLE, last_grant=loader (CPU wins first tie), cpu_ack=0, ldr_ack=0, err=0, rdata=0, busy=0.
REQ-032 rst asserted during ACCESS SHALL suppress ram_we that cycle (no partial store) and abort the access without ack.

Verification
REQ-033 CPU store word addr 0x010 data 0xDEADBEEF -> ram_we=1, ram_ww=1, ram_a=0x010 in ACCESS only; cpu_ack at N+2; subsequent read returns 0xDEADBEEF.
REQ-034 CPU byte read rb=1 at addr 0x013 with ram_rd=0x000000A5 -> rdata=0x000000A5, cpu_ack at N+2, err=0.
REQ-035 cpu_req and ldr_req both high from reset -> CPU granted first, loader second, alternating thereafter; ack pulses never overlap.
REQ-036 CPU word write addr 0x012 -> ram_we stays 0, err=1 with cpu_ack, memory unchanged.
REQ-037 Loader write addr 0x020, rst pulsed in ACCESS cycle -> ram_we=0, no ldr_ack, state IDLE next cycle, busy=0.
REQ-038 Byte read addr 0xFFF -> completes normally, err=0, no address wrap.
